// File: rtl/dma_burst_packer_pkg.sv
// Shared types and sizes for the DMA burst packer: write-FSM states and FIFO entry geometry.
package dma_inter_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACCEPT,
    W_DROP
  } w_state_t;

  localparam int DEPTH_DEF = 512;
  localparam int LVL_W     = $clog2(DEPTH_DEF) + 1;
  localparam int ENTRY_W   = 65;

endpackage

// File: rtl/dma_burst_packer_if.sv
// Upstream word strobe, AXI4-Stream output and statistics of the burst packer.
interface dma_burst_packer_if #(
  parameter int CNT_W = 16,
  parameter int LVL_W = 10
);
  logic             valid_in;
  logic [63:0]      data_in;
  logic             m_tvalid;
  logic [63:0]      m_tdata;
  logic             m_tlast;
  logic             m_tready;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [LVL_W-1:0] level;

  modport master (
    input  valid_in, data_in, m_tready,
    output m_tvalid, m_tdata, m_tlast, frame_cnt, drop_cnt, level
  );

  modport slave (
    output valid_in, data_in, m_tready,
    input  m_tvalid, m_tdata, m_tlast, frame_cnt, drop_cnt, level
  );
endinterface

// File: rtl/dma_burst_packer_fifo.sv
// Single-clock FIFO with show-ahead read data; the consumer registers it on pop.
module dma_sync_fifo #(
  parameter int DEPTH   = 512,
  parameter int ENTRY_W = 65,
  parameter int LVL_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty,
  output logic [LVL_W-1:0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  // Storage is never reset; only pointers and occupancy are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/dma_burst_packer.sv
// Packs fixed-length upstream bursts into AXI4-Stream frames; whole frames are admitted or dropped.
module dma_burst_packer
  import dma_inter_pkg::*;
#(
  parameter int BURST_LEN = 256,
  parameter int DEPTH     = 512,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  dma_burst_packer_if.master bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN);

  w_state_t state, state_nxt;

  logic [BW-1:0]      beat;
  logic               last_beat;
  logic               push, pop;
  logic               frame_inc, drop_inc;
  logic               fifo_full, fifo_empty;
  logic [LW-1:0]      fifo_level, free_space;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  logic               vld_p1;
  logic [63:0]        tdata_p1;
  logic               tlast_p1;
  logic [CNT_W-1:0]   frame_cnt, drop_cnt;

  assign last_beat  = (beat == BW'(BURST_LEN - 1));
  assign free_space = LW'(DEPTH) - fifo_level;
  assign wr_entry   = {last_beat, bus.data_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= W_IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (bus.valid_in) beat <= last_beat ? '0 : beat + BW'(1);
    end
  end

  // Admission looks at occupancy as registered when beat 0 arrives.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      W_IDLE: begin
        if (bus.valid_in) begin
          if (!fifo_full && free_space >= LW'(BURST_LEN)) begin
            push      = 1'b1;
            state_nxt = W_ACCEPT;
          end else begin
            state_nxt = W_DROP;
          end
        end
      end
      W_ACCEPT: begin
        if (bus.valid_in) begin
          push = 1'b1;
          if (last_beat) begin
            frame_inc = 1'b1;
            state_nxt = W_IDLE;
          end
        end
      end
      W_DROP: begin
        if (bus.valid_in && last_beat) begin
          drop_inc  = 1'b1;
          state_nxt = W_IDLE;
        end
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  dma_sync_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .LVL_W   (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Output stage p1: refill when empty or being consumed.
  assign pop = !fifo_empty && (!vld_p1 || bus.m_tready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (pop) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= rd_entry[63:0];
      tlast_p1 <= rd_entry[64];
    end else if (bus.m_tready) begin
      vld_p1   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_inc) frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign bus.m_tvalid  = vld_p1;
  assign bus.m_tdata   = tdata_p1;
  assign bus.m_tlast   = tlast_p1;
  assign bus.frame_cnt = frame_cnt;
  assign bus.drop_cnt  = drop_cnt;
  assign bus.level     = fifo_level;

endmodule

// File: tb/tb_dma_burst_packer.sv
// Scoreboard bench for dma_burst_packer: ordering, framing, admission boundaries, reset and counters.
module tb_dma_burst_packer;
  localparam int BL    = 256;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  dma_burst_packer_if #(.CNT_W(16), .LVL_W(10)) bus ();
  dma_burst_packer_if #(.CNT_W(4),  .LVL_W(2))  sbus ();

  dma_burst_packer #(.BURST_LEN(BL), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dma_burst_packer #(.BURST_LEN(2), .DEPTH(2), .CNT_W(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [64:0] sbq [$];
  int          beats = 0;
  int          lasts = 0;
  int          first_vld_cyc = -1;
  int          ovf = 0;
  int          exp_frames = 0;
  int          exp_drops = 0;
  bit          rand_rdy = 1'b0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: stall stability, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (u_dut.u_fifo.push && u_dut.u_fifo.full) ovf++;
    if (u_sat.u_fifo.push && u_sat.u_fifo.full) ovf++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_vld",  64'(bus.m_tvalid), 64'd1);
        chk("hold_data", bus.m_tdata, prev_data);
        chk("hold_last", 64'(bus.m_tlast), 64'(prev_last));
      end
      if (bus.m_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.m_tvalid && bus.m_tready) begin
        if (sbq.size() == 0) begin
          chk("sb_underrun", 64'(sbq.size()), 64'd1);
        end else begin
          logic [64:0] e;
          e = sbq.pop_front();
          chk("data", bus.m_tdata, e[63:0]);
          chk("last", 64'(bus.m_tlast), 64'(e[64]));
        end
        beats++;
        if (bus.m_tlast) lasts++;
      end
      stall_prev = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
      prev_last  = bus.m_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input int fid, input int n, input bit admit, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.valid_in = 1'b0;
        tick();
      end
      bus.valid_in = 1'b1;
      bus.data_in  = {32'(fid), 32'(i)};
      if (admit) sbq.push_back({(i == BL - 1), 32'(fid), 32'(i)});
      tick();
    end
    bus.valid_in = 1'b0;
    if (n == BL) begin
      if (admit) exp_frames++;
      else exp_drops++;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sbq.size() != 0 || bus.m_tvalid) && k < 5000) begin
      tick();
      k++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(bus.m_tvalid), 64'd0);
    chk({tag, "_tdata"},  bus.m_tdata, 64'd0);
    chk({tag, "_tlast"},  64'(bus.m_tlast), 64'd0);
    chk({tag, "_frames"}, 64'(bus.frame_cnt), 64'd0);
    chk({tag, "_drops"},  64'(bus.drop_cnt), 64'd0);
    chk({tag, "_level"},  64'(bus.level), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int drive_cyc;
    int k;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.m_tready  = 1'b0;
    sbus.valid_in = 1'b0;
    sbus.data_in  = '0;
    sbus.m_tready = 1'b0;

    // Reset values, then one contiguous frame with the sink always ready.
    tick(); tick();
    check_reset_outputs("rst0");
    rst = 1'b0;
    bus.m_tready = 1'b1;
    tick();
    beats = 0; lasts = 0; first_vld_cyc = -1;
    drive_cyc = cyc;
    send_frame(0, BL, 1'b1, 0);
    wait_drain();
    chk("t1_latency", 64'(first_vld_cyc), 64'(drive_cyc + 2));
    chk("t1_beats",   64'(beats), 64'(BL));
    chk("t1_lasts",   64'(lasts), 64'd1);
    chk("t1_frames",  64'(bus.frame_cnt), 64'(exp_frames));
    chk("t1_drops",   64'(bus.drop_cnt), 64'd0);

    // Stalled sink: fill, drop on overflow, then both admission boundaries.
    beats = 0; lasts = 0;
    bus.m_tready = 1'b0;
    send_frame(1, BL, 1'b1, 0);
    send_frame(2, BL, 1'b1, 0);
    tick();
    // The first word of frame 1 sits in the output register, not the FIFO.
    chk("t2_level_2f", 64'(bus.level), 64'(2 * BL - 1));
    send_frame(3, BL, 1'b0, 0);
    chk("t2_drops",    64'(bus.drop_cnt), 64'(exp_drops));
    chk("t2_level_dr", 64'(bus.level), 64'(2 * BL - 1));
    bus.m_tready = 1'b1;
    for (int i = 0; i < BL - 1; i++) tick();
    bus.m_tready = 1'b0;
    chk("t2_level_256", 64'(bus.level), 64'(DEPTH - BL));
    send_frame(4, BL, 1'b1, 0);
    chk("t2_level_full", 64'(bus.level), 64'(DEPTH));
    bus.m_tready = 1'b1;
    for (int i = 0; i < BL - 1; i++) tick();
    bus.m_tready = 1'b0;
    chk("t2_level_257", 64'(bus.level), 64'(DEPTH - BL + 1));
    send_frame(5, BL, 1'b0, 0);
    chk("t2_drops2",  64'(bus.drop_cnt), 64'(exp_drops));
    chk("t2_level_k", 64'(bus.level), 64'(DEPTH - BL + 1));
    bus.m_tready = 1'b1;
    wait_drain();
    chk("t2_beats",  64'(beats), 64'(3 * BL));
    chk("t2_lasts",  64'(lasts), 64'd3);
    chk("t2_frames", 64'(bus.frame_cnt), 64'(exp_frames));

    // Random backpressure and input gaps over 8 frames.
    beats = 0; lasts = 0;
    rand_rdy = 1'b1;
    for (int f = 0; f < 8; f++) begin
      k = 0;
      while (bus.level > 10'(DEPTH - BL) && k < 5000) begin
        tick();
        k++;
      end
      chk("t3_room", 64'(bus.level <= 10'(DEPTH - BL)), 64'd1);
      send_frame(10 + f, BL, 1'b1, 25);
    end
    rand_rdy = 1'b0;
    bus.m_tready = 1'b1;
    wait_drain();
    chk("t3_beats",  64'(beats), 64'(8 * BL));
    chk("t3_lasts",  64'(lasts), 64'd8);
    chk("t3_frames", 64'(bus.frame_cnt), 64'(exp_frames));
    chk("t3_drops",  64'(bus.drop_cnt), 64'(exp_drops));

    // Reset in the middle of a frame, then a clean frame.
    send_frame(30, 100, 1'b1, 0);
    rst = 1'b1;
    sbq.delete();
    #2;
    check_reset_outputs("rst_mid_a");
    tick();
    check_reset_outputs("rst_mid_b");
    rst = 1'b0;
    exp_frames = 0; exp_drops = 0;
    beats = 0; lasts = 0;
    tick();
    send_frame(31, BL, 1'b1, 0);
    wait_drain();
    chk("t4_beats",  64'(beats), 64'(BL));
    chk("t4_lasts",  64'(lasts), 64'd1);
    chk("t4_frames", 64'(bus.frame_cnt), 64'd1);

    // Drop-counter saturation on a small instance with a stalled sink.
    for (int f = 0; f < 19; f++) begin
      for (int w = 0; w < 2; w++) begin
        sbus.valid_in = 1'b1;
        sbus.data_in  = {32'(f), 32'(w)};
        tick();
      end
      sbus.valid_in = 1'b0;
      chk("sat_drops", 64'(sbus.drop_cnt), 64'((f > 15) ? 15 : f));
    end
    chk("sat_frames", 64'(sbus.frame_cnt), 64'd1);
    chk("sat_level",  64'(sbus.level), 64'd1);

    chk("no_overflow_write", 64'(ovf), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
